// File: rtl/csa_session_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csa_session_arbiter
// Brief    : Round-robin arbiter that runs whole accumulation sessions
//            (clear, stream, drain, terminate, capture) on one shared
//            carry-save accumulator on behalf of NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module csa_session_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int INPUT_LENGTH  = 16,
    parameter int OUTPUT_LENGTH = 32,
    parameter int MAX_WORDS     = 256
) (
    input  logic                              iClk,
    input  logic                              iRst,
    input  logic [NUM_REQ-1:0]                iReq,
    input  logic [NUM_REQ-1:0]                iValid,
    input  logic [NUM_REQ-1:0]                iLast,
    input  logic [NUM_REQ*INPUT_LENGTH-1:0]   iData,
    output logic [NUM_REQ-1:0]                oGrant,
    output logic [NUM_REQ-1:0]                oAck,
    output logic [OUTPUT_LENGTH-1:0]          oRes,
    output logic [NUM_REQ-1:0]                oResValid,
    output logic [$clog2(MAX_WORDS):0]        oCount,
    output logic                              oAccRst,
    output logic [INPUT_LENGTH-1:0]           oAccA,
    output logic                              oAccAccumulate,
    output logic                              oAccTerminate,
    input  logic [OUTPUT_LENGTH-1:0]          iAccRes,
    input  logic                              iAccReady,
    input  logic                              iAccDone
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MAX_WORDS) + 1;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CLEAR     = 3'd1;
    localparam logic [2:0] c_WAIT_RDY  = 3'd2;
    localparam logic [2:0] c_STREAM    = 3'd3;
    localparam logic [2:0] c_DRAIN     = 3'd4;
    localparam logic [2:0] c_TERM      = 3'd5;
    localparam logic [2:0] c_WAIT_DONE = 3'd6;
    localparam logic [2:0] c_RESULT    = 3'd7;

    logic [2:0]               r_state,  w_stateNext;
    logic [c_IDX_W-1:0]       r_ptr,    w_ptrNext;
    logic [c_IDX_W-1:0]       r_gIdx,   w_gIdxNext;
    logic [NUM_REQ-1:0]       r_grant,  w_grant;
    logic [NUM_REQ-1:0]       r_ack,    w_ack;
    logic [OUTPUT_LENGTH-1:0] r_res,    w_res;
    logic [NUM_REQ-1:0]       r_resValid, w_resValid;
    logic [c_CNT_W-1:0]       r_count,  w_count;
    logic [INPUT_LENGTH-1:0]  r_accA,   w_accA;
    logic                     r_accAccumulate, w_accAccumulate;
    logic                     r_accTerminate,  w_accTerminate;

    logic                     w_found;
    logic [c_IDX_W-1:0]       w_pick;
    logic [c_IDX_W:0]         w_cand;
    logic [INPUT_LENGTH-1:0]  w_opData;

    // First requester at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (c_IDX_W + 1)'(i);
            if (w_cand >= (c_IDX_W + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (c_IDX_W + 1)'(NUM_REQ);
            end
            if (!w_found && iReq[w_cand[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[c_IDX_W-1:0];
            end
        end
    end

    assign w_opData = iData[int'(r_gIdx)*INPUT_LENGTH +: INPUT_LENGTH];

    always_comb begin
        w_stateNext     = r_state;
        w_ptrNext       = r_ptr;
        w_gIdxNext      = r_gIdx;
        w_grant         = r_grant;
        w_ack           = '0;
        w_res           = r_res;
        w_resValid      = '0;
        w_count         = r_count;
        w_accA          = r_accA;
        w_accAccumulate = 1'b0;
        w_accTerminate  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_gIdxNext      = w_pick;
                    w_grant         = '0;
                    w_grant[w_pick] = 1'b1;
                    w_stateNext     = c_CLEAR;
                end
            end
            c_CLEAR: begin
                w_count     = '0;
                w_stateNext = c_WAIT_RDY;
            end
            c_WAIT_RDY: begin
                if (iAccReady) begin
                    w_stateNext = c_STREAM;
                end
            end
            c_STREAM: begin
                if (iValid[r_gIdx] && iAccReady) begin
                    w_accA          = w_opData;
                    w_accAccumulate = 1'b1;
                    w_ack[r_gIdx]   = 1'b1;
                    w_count         = r_count + 1'b1;
                    if (iLast[r_gIdx] || (w_count == c_CNT_W'(MAX_WORDS))) begin
                        w_stateNext = c_DRAIN;
                    end
                end
            end
            // Idle cycle lets the final add settle before terminate
            c_DRAIN: begin
                w_stateNext = c_TERM;
            end
            c_TERM: begin
                w_accTerminate = 1'b1;
                w_stateNext    = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                if (iAccDone) begin
                    w_res       = iAccRes;
                    w_stateNext = c_RESULT;
                end
            end
            c_RESULT: begin
                w_resValid[r_gIdx] = 1'b1;
                w_grant            = '0;
                w_ptrNext          = (r_gIdx == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_gIdx + 1'b1;
                w_stateNext        = c_IDLE;
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state         <= c_IDLE;
            r_ptr           <= '0;
            r_gIdx          <= '0;
            r_grant         <= '0;
            r_ack           <= '0;
            r_res           <= '0;
            r_resValid      <= '0;
            r_count         <= '0;
            r_accA          <= '0;
            r_accAccumulate <= 1'b0;
            r_accTerminate  <= 1'b0;
        end else begin
            r_state         <= w_stateNext;
            r_ptr           <= w_ptrNext;
            r_gIdx          <= w_gIdxNext;
            r_grant         <= w_grant;
            r_ack           <= w_ack;
            r_res           <= w_res;
            r_resValid      <= w_resValid;
            r_count         <= w_count;
            r_accA          <= w_accA;
            r_accAccumulate <= w_accAccumulate;
            r_accTerminate  <= w_accTerminate;
        end
    end

    assign oAccRst        = iRst | (r_state == c_CLEAR);
    assign oGrant         = r_grant;
    assign oAck           = r_ack;
    assign oRes           = r_res;
    assign oResValid      = r_resValid;
    assign oCount         = r_count;
    assign oAccA          = r_accA;
    assign oAccAccumulate = r_accAccumulate;
    assign oAccTerminate  = r_accTerminate;

endmodule
`default_nettype wire

// File: tb/tb_csa_session_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_session_arbiter
// Brief    : Directed bench for csa_session_arbiter with a behavioural
//            accumulator model; MAX_WORDS=4 so the cap path is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_session_arbiter;

    logic        clk = 1'b0;
    logic        iRst;
    logic [3:0]  iReq;
    logic [3:0]  iValid;
    logic [3:0]  iLast;
    logic [63:0] iData;
    logic [3:0]  oGrant;
    logic [3:0]  oAck;
    logic [31:0] oRes;
    logic [3:0]  oResValid;
    logic [2:0]  oCount;
    logic        oAccRst;
    logic [15:0] oAccA;
    logic        oAccAccumulate;
    logic        oAccTerminate;

    logic [31:0] accSum   = '0;
    logic [31:0] accRes   = '0;
    logic        accReady = 1'b0;
    logic        accDone  = 1'b0;
    int          termDly  = 0;

    int checks = 0;
    int errors = 0;
    int ackCnt [4];
    int termCnt = 0;
    int rvCnt = 0;
    logic [15:0] wv [4];

    always #5 clk = ~clk;

    csa_session_arbiter #(
        .NUM_REQ(4), .INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .MAX_WORDS(4)
    ) dut (
        .iClk(clk), .iRst(iRst), .iReq(iReq), .iValid(iValid), .iLast(iLast),
        .iData(iData), .oGrant(oGrant), .oAck(oAck), .oRes(oRes),
        .oResValid(oResValid), .oCount(oCount), .oAccRst(oAccRst),
        .oAccA(oAccA), .oAccAccumulate(oAccAccumulate),
        .oAccTerminate(oAccTerminate), .iAccRes(accRes),
        .iAccReady(accReady), .iAccDone(accDone)
    );

    // Accumulator: not ready for one cycle after reset, done 3 cycles after terminate
    always @(posedge clk) begin
        if (oAccRst) begin
            accSum <= '0; accReady <= 1'b0; accDone <= 1'b0; termDly <= 0;
        end else begin
            accReady <= 1'b1;
            accDone  <= 1'b0;
            if (oAccAccumulate) accSum <= accSum + {16'h0, oAccA};
            if (oAccTerminate) termDly <= 3;
            else if (termDly > 0) begin
                termDly <= termDly - 1;
                if (termDly == 1) begin accDone <= 1'b1; accRes <= accSum; end
            end
        end
    end

    initial for (int k = 0; k < 4; k++) ackCnt[k] = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) ackCnt[k] = ackCnt[k] + int'(oAck[k]);
        termCnt = termCnt + int'(oAccTerminate);
        if (oResValid != 4'b0) rvCnt = rvCnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        iRst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        iRst = 1'b0;
    endtask

    task automatic waitGrant(output logic [3:0] g);
        int it = 0;
        g = oGrant;
        while (g == 4'b0 && it < 50) begin
            @(negedge clk); it++; g = oGrant;
        end
        checks++;
        if (g == 4'b0) begin errors++; $display("FAIL grant_timeout: got %b required nonzero", g); end
    endtask

    task automatic waitResult(output logic [3:0] p, output logic [31:0] res);
        int it = 0;
        p = oResValid;
        while (p == 4'b0 && it < 80) begin
            @(negedge clk); it++; p = oResValid;
        end
        res = oRes;
        checks++;
        if (p == 4'b0) begin errors++; $display("FAIL result_timeout: got %b required nonzero", p); end
    endtask

    // Presents wv[0..n-1] on requester r, advancing on each oAck; mask stalls after the first ack
    task automatic streamWords(input int r, input int n, input bit lastFlag, input logic [7:0] mask,
                               output int span, output logic [2:0] cntAtLast);
        int idx = 0; int j = 0; int it = 0; int firstIt = 0; bit seen = 0;
        span = -1; cntAtLast = '0;
        iData[r*16 +: 16] = wv[0];
        iLast[r]  = lastFlag && (n == 1);
        iValid[r] = 1'b1;
        while (idx < n && it < 100) begin
            @(negedge clk); it++;
            if (oAck[r]) begin
                if (!seen) firstIt = it;
                seen = 1; idx++; span = it - firstIt; cntAtLast = oCount;
            end
            if (idx == n) begin
                iValid[r] = 1'b0; iLast[r] = 1'b0;
            end else begin
                iData[r*16 +: 16] = wv[idx];
                iLast[r] = lastFlag && (idx == n - 1);
                if (seen) begin
                    iValid[r] = (j < 8) ? !mask[j] : 1'b1; j++;
                end else iValid[r] = 1'b1;
            end
        end
        checks++;
        if (idx < n) begin errors++; $display("FAIL stream_timeout: got %0d acks required %0d", idx, n); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        iRst = 1'b1;
        @(negedge clk);
        checks++;
        if ({oGrant, oAck, oResValid} !== 12'h0 || oRes !== 32'h0 || oCount !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b ack=%b rv=%b res=%h cnt=%0d required all 0",
                     oGrant, oAck, oResValid, oRes, oCount);
        end
        checks++;
        if (oAccA !== 16'h0 || oAccAccumulate !== 1'b0 || oAccTerminate !== 1'b0 || oAccRst !== 1'b1) begin
            errors++;
            $display("FAIL reset_acc: got a=%h acc=%b term=%b rst=%b required 0 0 0 1",
                     oAccA, oAccAccumulate, oAccTerminate, oAccRst);
        end
        iRst = 1'b0;
        @(negedge clk);
        checks++;
        if (oAccRst !== 1'b0) begin errors++; $display("FAIL idle_accrst: got %b required 0", oAccRst); end
    endtask

    task automatic test_single();
        logic [3:0] g, p; logic [31:0] res; int span; logic [2:0] cnt;
        int a0 = ackCnt[0]; int t0 = termCnt;
        iReq[0] = 1'b1;
        waitGrant(g);
        checks++;
        if (g !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b required 0001", g); end
        wv[0] = 16'd3; wv[1] = 16'd5; wv[2] = 16'd7;
        streamWords(0, 3, 1'b1, 8'h00, span, cnt);
        iReq[0] = 1'b0;
        checks++;
        if (span !== 2) begin errors++; $display("FAIL single_b2b_span: got %0d required 2", span); end
        checks++;
        if (cnt !== 3'd3) begin errors++; $display("FAIL single_count: got %0d required 3", cnt); end
        waitResult(p, res);
        checks++;
        if (p !== 4'b0001 || res !== 32'd15) begin
            errors++; $display("FAIL single_result: got rv=%b res=%0d required 0001 15", p, res);
        end
        checks++;
        if (oCount !== 3'd3) begin errors++; $display("FAIL single_count_hold: got %0d required 3", oCount); end
        @(negedge clk);
        checks++;
        if (oResValid !== 4'b0) begin errors++; $display("FAIL single_rv_width: got %b required 0000", oResValid); end
        checks++;
        if (ackCnt[0] - a0 !== 3 || termCnt - t0 !== 1) begin
            errors++; $display("FAIL single_pulses: got acks=%0d terms=%0d required 3 1", ackCnt[0] - a0, termCnt - t0);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g, p; logic [31:0] res; int span; logic [2:0] cnt;
        do_reset();
        iReq = 4'b0101;
        waitGrant(g);
        checks++;
        if (g !== 4'b0001) begin errors++; $display("FAIL rr_first: got %b required 0001", g); end
        wv[0] = 16'd1; wv[1] = 16'd1;
        streamWords(0, 2, 1'b1, 8'h00, span, cnt);
        iReq[0] = 1'b0;
        waitResult(p, res);
        checks++;
        if (p !== 4'b0001 || res !== 32'd2) begin errors++; $display("FAIL rr_res0: got rv=%b res=%0d required 0001 2", p, res); end
        waitGrant(g);
        checks++;
        if (g !== 4'b0100) begin errors++; $display("FAIL rr_second: got %b required 0100", g); end
        wv[0] = 16'd2; wv[1] = 16'd2;
        streamWords(2, 2, 1'b1, 8'h00, span, cnt);
        iReq[2] = 1'b0;
        waitResult(p, res);
        checks++;
        if (p !== 4'b0100 || res !== 32'd4) begin errors++; $display("FAIL rr_res2: got rv=%b res=%0d required 0100 4", p, res); end
        @(negedge clk);
        iReq = 4'b1001;
        waitGrant(g);
        checks++;
        if (g !== 4'b1000) begin errors++; $display("FAIL rr_wrap: got %b required 1000", g); end
        wv[0] = 16'd5;
        streamWords(3, 1, 1'b1, 8'h00, span, cnt);
        iReq[3] = 1'b0;
        waitResult(p, res);
        checks++;
        if (p !== 4'b1000 || res !== 32'd5) begin errors++; $display("FAIL rr_res3: got rv=%b res=%0d required 1000 5", p, res); end
        waitGrant(g);
        checks++;
        if (g !== 4'b0001) begin errors++; $display("FAIL rr_after_wrap: got %b required 0001", g); end
        wv[0] = 16'd6;
        streamWords(0, 1, 1'b1, 8'h00, span, cnt);
        iReq[0] = 1'b0;
        waitResult(p, res);
        checks++;
        if (res !== 32'd6) begin errors++; $display("FAIL rr_res0b: got %0d required 6", res); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] g, p; logic [31:0] res; int span; logic [2:0] cnt;
        iReq[1] = 1'b1;
        waitGrant(g);
        wv[0] = 16'hFFFF; wv[1] = 16'h0001;
        streamWords(1, 2, 1'b1, 8'h00, span, cnt);
        iReq[1] = 1'b0;
        waitResult(p, res);
        checks++;
        if (p !== 4'b0010 || res !== 32'h0001_0000) begin
            errors++; $display("FAIL b2b_first: got rv=%b res=%h required 0010 00010000", p, res);
        end
        iReq[1] = 1'b1;
        waitGrant(g);
        checks++;
        if (g !== 4'b0010) begin errors++; $display("FAIL b2b_regrant: got %b required 0010", g); end
        wv[0] = 16'd10;
        streamWords(1, 1, 1'b1, 8'h00, span, cnt);
        iReq[1] = 1'b0;
        waitResult(p, res);
        checks++;
        if (res !== 32'd10) begin errors++; $display("FAIL b2b_second: got %0d required 10", res); end
    endtask

    task automatic test_stall_cap();
        logic [3:0] g, p; logic [31:0] res; int span; logic [2:0] cnt;
        int a0 = ackCnt[0];
        iReq[0] = 1'b1;
        waitGrant(g);
        wv[0] = 16'h1000; wv[1] = 16'h0200; wv[2] = 16'h0030; wv[3] = 16'h0004;
        streamWords(0, 4, 1'b0, 8'h01, span, cnt);
        iReq[0] = 1'b0;
        iData[15:0] = 16'h0064;
        iValid[0] = 1'b1;
        checks++;
        if (span !== 4 || cnt !== 3'd4) begin errors++; $display("FAIL cap_span_count: got span=%0d cnt=%0d required 4 4", span, cnt); end
        waitResult(p, res);
        iValid[0] = 1'b0;
        checks++;
        if (p !== 4'b0001 || res !== 32'h1234) begin errors++; $display("FAIL cap_result: got rv=%b res=%h required 0001 1234", p, res); end
        @(negedge clk);
        checks++;
        if (ackCnt[0] - a0 !== 4) begin errors++; $display("FAIL cap_acks: got %0d required 4", ackCnt[0] - a0); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g, p; logic [31:0] res; int span; logic [2:0] cnt;
        int rv0;
        iReq[0] = 1'b1;
        waitGrant(g);
        wv[0] = 16'd7; wv[1] = 16'd8;
        streamWords(0, 2, 1'b0, 8'h00, span, cnt);
        iReq[0] = 1'b0;
        rv0 = rvCnt;
        iRst = 1'b1;
        @(negedge clk);
        checks++;
        if ({oGrant, oAck, oResValid} !== 12'h0 || oCount !== 3'd0 || oRes !== 32'h0 || oAccRst !== 1'b1 || oAccAccumulate !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got grant=%b ack=%b rv=%b cnt=%0d res=%h accrst=%b required 0s and accrst=1",
                     oGrant, oAck, oResValid, oCount, oRes, oAccRst);
        end
        iRst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (rvCnt !== rv0) begin errors++; $display("FAIL midrst_no_result: got %0d strobes required 0", rvCnt - rv0); end
        iReq[0] = 1'b1;
        waitGrant(g);
        wv[0] = 16'd9;
        streamWords(0, 1, 1'b1, 8'h00, span, cnt);
        iReq[0] = 1'b0;
        waitResult(p, res);
        checks++;
        if (p !== 4'b0001 || res !== 32'd9) begin errors++; $display("FAIL midrst_fresh: got rv=%b res=%0d required 0001 9", p, res); end
    endtask

    task automatic test_noise();
        logic [3:0] g, p; logic [31:0] res; int span; logic [2:0] cnt;
        int a1;
        @(negedge clk);
        a1 = ackCnt[1];
        iData[31:16] = 16'hAAAA; iValid[1] = 1'b1; iLast[1] = 1'b1;
        iReq[2] = 1'b1;
        waitGrant(g);
        checks++;
        if (g !== 4'b0100) begin errors++; $display("FAIL noise_grant: got %b required 0100", g); end
        wv[0] = 16'h0011; wv[1] = 16'h0022;
        streamWords(2, 2, 1'b1, 8'h00, span, cnt);
        iReq[2] = 1'b0;
        waitResult(p, res);
        checks++;
        if (p !== 4'b0100 || res !== 32'h33) begin errors++; $display("FAIL noise_result: got rv=%b res=%h required 0100 33", p, res); end
        @(negedge clk);
        iValid[1] = 1'b0; iLast[1] = 1'b0;
        checks++;
        if (ackCnt[1] - a1 !== 0) begin errors++; $display("FAIL noise_ack: got %0d acks required 0", ackCnt[1] - a1); end
    endtask

    initial begin
        iRst = 1'b1; iReq = '0; iValid = '0; iLast = '0; iData = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_stall_cap();
        test_reset_mid();
        test_noise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa_session_arbiter.md
Name: csa_session_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one carry_save_accumulator between NUM_REQ requesters.
- Each grant is a full accumulation session:
  - clear the accumulator;
  - stream the requester's operands until its last flag;
  - drain;
  - terminate;
  - capture the final sum and return it to the owning requester.
- Sits between requester stream ports and the accumulator's iA/iAccumulate/iTerminate/oRes/oReady/oDone pins; also owns the accumulator reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- INPUT_LENGTH, 16, operand width; must match the accumulator.
- OUTPUT_LENGTH, 32, result width; must match the accumulator.
- MAX_WORDS, 256, operand cap per session; the word at count MAX_WORDS is treated as last.

Ports:
- iClk  in  1  clock.
- iRst  in  1  synchronous active-high reset.
- iReq  in  NUM_REQ  per-requester session request.
- iValid  in  NUM_REQ  per-requester operand valid.
- iLast  in  NUM_REQ  per-requester last-operand flag, qualified by iValid.
- iData  in  NUM_REQ*INPUT_LENGTH  packed operands; requester k occupies bits [k*INPUT_LENGTH +: INPUT_LENGTH].
- oGrant  out  NUM_REQ  one-hot session owner.
- oAck  out  NUM_REQ  one-hot operand-consumed strobe.
- oRes  out  OUTPUT_LENGTH  last captured sum.
- oResValid  out  NUM_REQ  one-hot one-cycle result strobe.
- oCount  out  clog2(MAX_WORDS)+1  operands accepted in the current session.
- oAccRst  out  1  accumulator reset.
- oAccA  out  INPUT_LENGTH  accumulator operand.
- oAccAccumulate  out  1  accumulator add strobe.
- oAccTerminate  out  1  accumulator terminate strobe.
- iAccRes  in  OUTPUT_LENGTH  accumulator oRes.
- iAccReady  in  1  accumulator oReady.
- iAccDone  in  1  accumulator oDone.

Behaviour:
- One clock, iClk. Reset is synchronous and active-high on iRst.
- Reset values:
  - oGrant, oAck, oResValid, oRes, oCount, oAccA, oAccAccumulate, oAccTerminate all 0.
  - Round-robin pointer 0; FSM in IDLE.
- oAccRst = iRst OR (state==CLEAR), combinational. Global reset therefore always clears the accumulator. Reset mid-session aborts the session with no oResValid.
- All other outputs are registered.
- FSM:
  - IDLE:
    - If any iReq is set, grant the first requester at or after the pointer (wrapping), register oGrant one-hot, and go to CLEAR.
    - If no iReq, stay.
  - CLEAR:
    - One cycle; oAccRst=1; oCount<=0; then go to WAIT_RDY.
  - WAIT_RDY:
    - Wait for iAccReady=1; it is low for one cycle after accumulator reset.
    - Then go to STREAM.
  - STREAM, for granted requester g:
    - When iValid[g]=1 and iAccReady=1: oAccA<=iData[g], oAccAccumulate<=1, oAck[g]<=1, oCount+=1, all for one cycle each.
    - Back-to-back acceptance every cycle is allowed.
    - If iLast[g]=1 or the new count equals MAX_WORDS, go to DRAIN.
    - If iValid[g]=0, stall indefinitely; there is no timeout.
  - DRAIN:
    - One cycle with no strobes, so the last operand is absorbed before terminate.
    - Then go to TERM.
  - TERM:
    - oAccTerminate=1 for exactly one cycle; then go to WAIT_DONE.
  - WAIT_DONE:
    - On iAccDone=1, oRes<=iAccRes and go to RESULT.
  - RESULT:
    - oResValid[g]=1 for one cycle; oGrant<=0; pointer<=(g+1) mod NUM_REQ; go to IDLE.
- Once granted, iReq[g] is ignored until RESULT. Dropping iReq mid-session does not abort the session.
- Zero-operand session: iReq is set but the first word carries iLast. That word is still accumulated, so the minimum session is 1 word.
- iValid/iLast/iData of non-granted requesters are ignored; oAck is never set for them.
- oRes holds its value until the next capture.
- A new request raised during RESULT is arbitrated in the following IDLE cycle.
- Sum width rule: the integrator guarantees OUTPUT_LENGTH >= INPUT_LENGTH + clog2(MAX_WORDS). The block does not detect overflow.
- Session latency: grant to first accept is at least 3 cycles (IDLE, CLEAR, WAIT_RDY). Last accept to oResValid is 3 cycles plus the accumulator processing time.

Test Plan:
- Single requester: req0 streams 3, 5, 7 (last on 7) with iValid held → oAck0 on 3 consecutive cycles; one oAccTerminate pulse; oRes=15; oResValid=0001 for 1 cycle; oCount=3.
- Round-robin: req0 and req2 asserted together from reset, each with 2-word sessions {1,1} and {2,2} → req0 served first with oRes=2, then req2 with oRes=4; then req0 raised again while req3 is raised → req3 is granted before req0.
- Back-to-back sessions: req1 sends {0xFFFF, 0x0001}, then {10} → oRes=0x00010000, then 10; no carry-over, confirming oAccRst in CLEAR.
- Stall and cap: MAX_WORDS=4; req0 iValid toggles 1,0,1,1,1 with no iLast → exactly 4 oAck pulses, auto-terminate, oRes equals the sum of the 4 words, and no fifth oAck.
- Reset mid-STREAM: assert iRst after 2 accepted words → next cycle all outputs are 0, oAccRst=1, no oResValid; a fresh session {9} afterwards yields 9.
- Non-granted noise: req2 is granted while req1 drives iValid/iLast with data 0xAAAA → req1 receives no oAck and the result reflects req2's data only.
